wave_history_ctrl: RTL and testbench
====================================

# wave_history_ctrl

Write-side sequencer for the volume-bar waveform history RAM. Paces volume samples at a software-selected rate and replicates each sample across the configured bar thickness. Runs full-buffer clear sweeps and owns the bar spacing/thickness configuration. Sits between the volume/menu logic and the dual-port history RAM, whose read port the pixel renderer scans independently.

## Interface
- HIST_DEPTH, 96, number of history entries (one per display column)
- ADDR_W, 7, history address width; must satisfy 2^ADDR_W ≥ HIST_DEPTH + 8
- VOL_W, 6, volume sample width
---
- clk_20khz  in  1  sample-domain clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; one clock, asynchronous active-high reset
- volume_level  in  VOL_W  current volume, sampled when a sample is due
- selected_count  in  20  sample period minus one, in clk_20khz cycles
- pause_switch  in  1  freezes all state; button pulses ignored
- menu_switch, SW_2  in  1  either high blocks spacing changes
- pb_left, pb_right, pb_up, pb_clear, pb_down  in  1  single-cycle button pulses
- wr_en  out  1  history RAM write strobe
- wr_addr  out  ADDR_W  history RAM write address
- wr_data  out  VOL_W  history RAM write data
- head_index  out  ADDR_W  next sample column
- bar_space  out  4  one-hot, one of 1/2/4/8
- bar_thickness  out  4  one-hot, one of 1/2/4/8
- clear_busy  out  1  clear sweep in progress
- hilite_valid  out  1  highlight window valid
- hilite_lo  out  ADDR_W  highlight window lower bound
- hilite_hi  out  ADDR_W+1  highlight window upper bound

## Operation
- States:
  - CLEAR: sweeps clr_addr from 0 to HIST_DEPTH-1, writing 0. On the last address: head←0, →IDLE.
  - IDLE: pace counter increments each cycle. When cnt ≥ selected_count: cnt←0, latch volume_level, burst_addr←head, →BURST.
  - BURST: writes the latched value at burst_addr, run times, one per cycle. Then head←(head+space ≥ HIST_DEPTH) ? 0 : head+space, →IDLE.
- run = min(thickness, space). Burst writes with address ≥ HIST_DEPTH are suppressed but still consume their cycle.
- Pace counter: held at 0 in CLEAR, frozen in BURST. Sample period = selected_count+1+run cycles.
- pb_right: space ≪1 if space<8. pb_left: space ≫1 if space>1. Both require menu_switch=0 and SW_2=0. An accepted change forces CLEAR from address 0, aborting any burst or sweep.
- pb_right and pb_left in the same cycle: pb_right wins, pb_left ignored.
- pb_clear: forces CLEAR from address 0 in any state, including restarting an active sweep.
- pb_up: thickness cycles 1→2→4→8→1. Takes effect at the next burst; never triggers a clear.
- Sample due in the same cycle as an accepted clear/space change: clear wins, sample dropped.
- pause_switch=1: state, counters, head and config hold; wr_en=0; pulses discarded.
- Reset values:
  - state=CLEAR, clr_addr=0, head_index=0, cnt=0
  - bar_space=4'b0001, bar_thickness=4'b0001
  - wr_en=0, wr_addr=0, wr_data=0, clear_busy=0
  - hilite outputs 0, hilite_sel=0
- A fresh sweep starts on the first edge after reset deasserts. Reset asserted mid-sweep or mid-burst aborts immediately.

## Timing
- Write outputs and clear_busy are registered. The write decided in cycle n is presented with wr_en=1 in cycle n+1.
- Clear: HIST_DEPTH consecutive wr_en cycles, addresses 0..HIST_DEPTH-1 ascending, wr_data=0. clear_busy is high on exactly those cycles.
- Sample: first burst write appears 1 cycle after the cnt ≥ selected_count edge. Burst writes are back-to-back with consecutive addresses.
- head_index updates in the cycle after the last burst write.
- Config outputs update on the edge following the accepted pulse.

## Configuration
- WAVE_HIST_HILITE_EN defined:
  - 2-bit hilite_sel increments (wrapping) on pb_down.
  - w = hilite_sel·space.
  - hilite_valid = (hilite_sel≠0) && (head ≥ w).
  - hilite_lo = head−w, hilite_hi = head+w−1.
  - All registered; recomputed every unpaused cycle.
- Undefined: hilite_sel not implemented; hilite_valid, hilite_lo, hilite_hi tied to 0; pb_down ignored.

## Structure
- Shared package wave_pkg holds:
  - HIST_DEPTH, VOL_W, ADDR_W defaults
  - state enum {CLEAR, IDLE, BURST}
  - one-hot space/thickness constants SP_1/2/4/8
- One sub-module, sample_pacer: the 20-bit counter with clear/hold/due logic.

## Test plan
- Reset release → 96 writes of 0 at addresses 0..95 on consecutive cycles, clear_busy high throughout, then head_index=0.
- selected_count=4, space=1, thickness=1, volume_level=17 → writes (0,17), (1,17), … with one write every 6 cycles; head wraps 95→0.
- 2× pb_right then 2× pb_up (space=4, thickness=4), each change completing its clear sweep; volume 9 → bursts to 0..3, 4..7, …; head steps by 4.
- pb_right with menu_switch=1 → bar_space unchanged, no clear. pb_right+pb_left same cycle → space doubles, one clear sweep.
- pb_clear at clr_addr=50 → sweep restarts at address 0; pause_switch=1 mid-burst → wr_en low, addresses resume unchanged on release.
- WAVE_HIST_HILITE_EN, space=2, head=10, 2× pb_down → hilite_valid=1, lo=6, hi=13. At head=2 → hilite_valid=0.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared types and constants for the waveform history write sequencer.
package wave_pkg;

    localparam int HIST_DEPTH = 96;
    localparam int ADDR_W     = 7;
    localparam int VOL_W      = 6;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        BURST
    } state_t;

    localparam logic [3:0] SP_1 = 4'b0001;
    localparam logic [3:0] SP_2 = 4'b0010;
    localparam logic [3:0] SP_4 = 4'b0100;
    localparam logic [3:0] SP_8 = 4'b1000;

    // One-hot codes double as their numeric value, so a plain compare gives the minimum.
    function automatic logic [3:0] run_len(input logic [3:0] thick, input logic [3:0] space);
        return (thick < space) ? thick : space;
    endfunction

endpackage

// File: rtl/wave_history_ctrl_if.sv
// Write port bundle towards the dual-port history RAM.
interface wave_history_ctrl_if #(
    parameter int ADDR_W = wave_pkg::ADDR_W,
    parameter int VOL_W  = wave_pkg::VOL_W
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [VOL_W-1:0]  wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/sample_pacer.sv
// Sample-rate pace counter: clear, hold and due detection.
module sample_pacer #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             hold,
    input  logic [CNT_W-1:0] limit,
    output logic             due
);
    logic [CNT_W-1:0] cnt;

    assign due = (cnt >= limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= due ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/wave_history_ctrl.sv
// Write-side sequencer for the volume-bar history RAM (clear sweeps, paced bursts, bar config).
// Optional highlight window enabled by defining WAVE_HIST_HILITE_EN.
module wave_history_ctrl #(
    parameter int HIST_DEPTH = wave_pkg::HIST_DEPTH,
    parameter int ADDR_W     = wave_pkg::ADDR_W,
    parameter int VOL_W      = wave_pkg::VOL_W
) (
    input  logic                clk_20khz,
    input  logic                reset,
    input  logic [VOL_W-1:0]    volume_level,
    input  logic [19:0]         selected_count,
    input  logic                pause_switch,
    input  logic                menu_switch,
    input  logic                SW_2,
    input  logic                pb_left,
    input  logic                pb_right,
    input  logic                pb_up,
    input  logic                pb_clear,
    input  logic                pb_down,
    wave_history_ctrl_if.master wr,
    output logic [ADDR_W-1:0]   head_index,
    output logic [3:0]          bar_space,
    output logic [3:0]          bar_thickness,
    output logic                clear_busy,
    output logic                hilite_valid,
    output logic [ADDR_W-1:0]   hilite_lo,
    output logic [ADDR_W:0]     hilite_hi
);
    import wave_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(HIST_DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(HIST_DEPTH);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] clr_addr, clr_nx;
    logic [ADDR_W-1:0] head, head_nx;
    logic [ADDR_W-1:0] burst_addr, baddr_nx;
    logic [3:0]        burst_left, left_nx;
    logic [VOL_W-1:0]  vol_q, vol_nx;
    logic [3:0]        space, space_nx;
    logic [3:0]        thick, thick_nx;
    logic              en_nx, busy_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [VOL_W-1:0]  data_nx;
    logic [ADDR_W:0]   head_step;
    logic              cfg_ok, space_up, space_dn, force_clr, due;

    assign cfg_ok    = !menu_switch && !SW_2;
    assign space_up  = pb_right && cfg_ok && (space != SP_8);
    assign space_dn  = pb_left && !pb_right && cfg_ok && (space != SP_1);
    assign force_clr = space_up || space_dn || pb_clear;
    assign head_step = {1'b0, head} + {{(ADDR_W-3){1'b0}}, space};

    sample_pacer #(.CNT_W(20)) u_pacer (
        .clk   (clk_20khz),
        .rst   (reset),
        .clear (!pause_switch && (force_clr || state == CLEAR)),
        .hold  (pause_switch || state == BURST),
        .limit (selected_count),
        .due   (due)
    );

    always_comb begin
        state_nx = state;
        clr_nx   = clr_addr;
        head_nx  = head;
        baddr_nx = burst_addr;
        left_nx  = burst_left;
        vol_nx   = vol_q;
        space_nx = space;
        thick_nx = thick;
        en_nx    = 1'b0;
        addr_nx  = wr.wr_addr;
        data_nx  = wr.wr_data;
        busy_nx  = 1'b0;
        if (!pause_switch) begin
            if (pb_up) thick_nx = {thick[2:0], thick[3]};
            if (space_up)      space_nx = {space[2:0], 1'b0};
            else if (space_dn) space_nx = {1'b0, space[3:1]};
            // A forced clear pre-empts whatever the current state would have written or sampled.
            if (force_clr) begin
                state_nx = CLEAR;
                clr_nx   = '0;
            end else begin
                case (state)
                    CLEAR: begin
                        en_nx   = 1'b1;
                        addr_nx = clr_addr;
                        data_nx = '0;
                        busy_nx = 1'b1;
                        if (clr_addr == LAST_ADDR) begin
                            clr_nx   = '0;
                            head_nx  = '0;
                            state_nx = IDLE;
                        end else begin
                            clr_nx = clr_addr + 1'b1;
                        end
                    end
                    IDLE: begin
                        if (due) begin
                            vol_nx   = volume_level;
                            baddr_nx = head;
                            left_nx  = run_len(thick, space);
                            state_nx = BURST;
                        end
                    end
                    BURST: begin
                        en_nx    = ({1'b0, burst_addr} < DEPTH_X);
                        addr_nx  = burst_addr;
                        data_nx  = vol_q;
                        baddr_nx = burst_addr + 1'b1;
                        left_nx  = burst_left - 1'b1;
                        if (burst_left == 4'd1) begin
                            head_nx  = (head_step >= DEPTH_X) ? '0 : head_step[ADDR_W-1:0];
                            state_nx = IDLE;
                        end
                    end
                    default: state_nx = CLEAR;
                endcase
            end
        end
    end

    always_ff @(posedge clk_20khz or posedge reset) begin
        if (reset) begin
            state      <= CLEAR;
            clr_addr   <= '0;
            head       <= '0;
            burst_addr <= '0;
            burst_left <= '0;
            vol_q      <= '0;
            space      <= SP_1;
            thick      <= SP_1;
            wr.wr_en   <= 1'b0;
            wr.wr_addr <= '0;
            wr.wr_data <= '0;
            clear_busy <= 1'b0;
        end else begin
            state      <= state_nx;
            clr_addr   <= clr_nx;
            head       <= head_nx;
            burst_addr <= baddr_nx;
            burst_left <= left_nx;
            vol_q      <= vol_nx;
            space      <= space_nx;
            thick      <= thick_nx;
            wr.wr_en   <= en_nx;
            wr.wr_addr <= addr_nx;
            wr.wr_data <= data_nx;
            clear_busy <= busy_nx;
        end
    end

    assign head_index    = head;
    assign bar_space     = space;
    assign bar_thickness = thick;

`ifdef WAVE_HIST_HILITE_EN
    logic [1:0]      hsel;
    logic [ADDR_W:0] hwidth;

    assign hwidth = (ADDR_W+1)'(hsel) * (ADDR_W+1)'(space);

    always_ff @(posedge clk_20khz or posedge reset) begin
        if (reset) begin
            hsel         <= '0;
            hilite_valid <= 1'b0;
            hilite_lo    <= '0;
            hilite_hi    <= '0;
        end else if (!pause_switch) begin
            if (pb_down) hsel <= hsel + 1'b1;
            hilite_valid <= (hsel != 2'd0) && ({1'b0, head} >= hwidth);
            hilite_lo    <= head - hwidth[ADDR_W-1:0];
            hilite_hi    <= {1'b0, head} + hwidth - 1'b1;
        end
    end
`else
    logic unused_down;
    assign unused_down  = pb_down;
    assign hilite_valid = 1'b0;
    assign hilite_lo    = '0;
    assign hilite_hi    = '0;
`endif

endmodule

// File: tb/tb_wave_history_ctrl.sv
// Directed bench for wave_history_ctrl: vector table over bar configs plus multi-cycle corner sequences.
module tb_wave_history_ctrl;
    import wave_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [VOL_W-1:0]  volume_level;
    logic [19:0]       selected_count;
    logic              pause_switch, menu_switch, SW_2;
    logic              pb_left, pb_right, pb_up, pb_clear, pb_down;
    logic [ADDR_W-1:0] head_index;
    logic [3:0]        bar_space, bar_thickness;
    logic              clear_busy, hilite_valid;
    logic [ADDR_W-1:0] hilite_lo;
    logic [ADDR_W:0]   hilite_hi;

    wave_history_ctrl_if #(.ADDR_W(ADDR_W), .VOL_W(VOL_W)) wr_bus ();

    wave_history_ctrl #(.HIST_DEPTH(HIST_DEPTH), .ADDR_W(ADDR_W), .VOL_W(VOL_W)) dut (
        .clk_20khz      (clk),
        .reset          (reset),
        .volume_level   (volume_level),
        .selected_count (selected_count),
        .pause_switch   (pause_switch),
        .menu_switch    (menu_switch),
        .SW_2           (SW_2),
        .pb_left        (pb_left),
        .pb_right       (pb_right),
        .pb_up          (pb_up),
        .pb_clear       (pb_clear),
        .pb_down        (pb_down),
        .wr             (wr_bus),
        .head_index     (head_index),
        .bar_space      (bar_space),
        .bar_thickness  (bar_thickness),
        .clear_busy     (clear_busy),
        .hilite_valid   (hilite_valid),
        .hilite_lo      (hilite_lo),
        .hilite_hi      (hilite_hi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        int n_right;
        int n_left;
        int n_up;
        int sel;
        int vol;
        int exp_space;
        int exp_thick;
        int exp_run;
    } vec_t;

    vec_t vt[6];
    int   m_space = 1;
    int   m_thick = 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int step(input int a, input int s);
        return (a + s >= HIST_DEPTH) ? 0 : a + s;
    endfunction

    task automatic pulse(input int which);
        case (which)
            0: pb_right = 1'b1;
            1: pb_left  = 1'b1;
            2: pb_up    = 1'b1;
            3: pb_clear = 1'b1;
            4: pb_down  = 1'b1;
            default: begin
                pb_right = 1'b1;
                pb_left  = 1'b1;
            end
        endcase
        @(negedge clk);
        {pb_right, pb_left, pb_up, pb_clear, pb_down} = '0;
    endtask

    task automatic expect_sweep(output int last_cyc);
        int k = 0;
        int bad_i = -1;
        last_cyc = cyc;
        while (!clear_busy && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("sweep_start", int'(clear_busy), 1);
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (bad_i < 0 && !(wr_bus.wr_en === 1'b1 && int'(wr_bus.wr_addr) == i &&
                               wr_bus.wr_data == '0 && clear_busy === 1'b1))
                bad_i = i;
            last_cyc = cyc;
            @(negedge clk);
        end
        chk("sweep_first_bad_index", bad_i, -1);
        chk("sweep_end_wr_en", int'(wr_bus.wr_en), 0);
        chk("sweep_end_busy", int'(clear_busy), 0);
        chk("sweep_head", int'(head_index), 0);
    endtask

    task automatic capture_burst(output int st, output int a0, output int len,
                                 output int d0, output int hd, output int bad);
        int k = 0;
        st = 0; a0 = -1; len = 0; d0 = -1; hd = -1; bad = 0;
        while (!(wr_bus.wr_en && !clear_busy) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (!(wr_bus.wr_en && !clear_busy)) begin
            chk("burst_timeout", 0, 1);
            return;
        end
        st = cyc;
        a0 = int'(wr_bus.wr_addr);
        d0 = int'(wr_bus.wr_data);
        while (wr_bus.wr_en && len < 20) begin
            if (int'(wr_bus.wr_addr) != a0 + len || int'(wr_bus.wr_data) != d0) bad = 1;
            len++;
            @(negedge clk);
        end
        hd = int'(head_index);
    endtask

    task automatic watch_no_clear(input string name, input int n);
        int hits = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (clear_busy) hits++;
        end
        chk(name, hits, 0);
    endtask

    task automatic wait_head(input int h, input int bound);
        int k = 0;
        while (int'(head_index) != h && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk("wait_head", int'(head_index), h);
    endtask

    initial begin
        int lc, st, a0, len, d0, hd, bad;
        int bst, ba0, blen, bd0, bhd, bbad;
        int prev, seen, k, a, h0, paused_wr;

        vt[0] = '{0, 0, 0, 4, 17, 1, 1, 1};
        vt[1] = '{2, 0, 2, 4,  9, 4, 4, 4};
        vt[2] = '{0, 1, 0, 2, 33, 2, 4, 2};
        vt[3] = '{0, 0, 1, 0, 63, 2, 8, 2};
        vt[4] = '{2, 0, 1, 7,  5, 8, 1, 1};
        vt[5] = '{1, 3, 1, 1, 40, 1, 2, 1};

        reset = 1'b1;
        volume_level = 6'd17;
        selected_count = 20'd4;
        {pause_switch, menu_switch, SW_2} = '0;
        {pb_right, pb_left, pb_up, pb_clear, pb_down} = '0;
        repeat (3) @(negedge clk);

        chk("rst_wr_en", int'(wr_bus.wr_en), 0);
        chk("rst_wr_addr", int'(wr_bus.wr_addr), 0);
        chk("rst_wr_data", int'(wr_bus.wr_data), 0);
        chk("rst_clear_busy", int'(clear_busy), 0);
        chk("rst_head", int'(head_index), 0);
        chk("rst_space", int'(bar_space), 1);
        chk("rst_thick", int'(bar_thickness), 1);
        chk("rst_hilite", int'({hilite_valid, hilite_lo, hilite_hi}), 0);

        reset = 1'b0;
        @(negedge clk);
        chk("first_sweep_wr_en", int'(wr_bus.wr_en), 1);
        chk("first_sweep_addr", int'(wr_bus.wr_addr), 0);
        expect_sweep(lc);

        // First sample after the sweep, then steady one-column steps.
        capture_burst(st, a0, len, d0, hd, bad);
        chk("first_sample_gap", st - lc, 6);
        chk("first_sample_addr", a0, 0);
        chk("first_sample_data", d0, 17);
        chk("first_sample_len", len, 1);
        capture_burst(bst, ba0, blen, bd0, bhd, bbad);
        chk("second_sample_addr", ba0, 1);
        chk("sample_period_sel4", bst - st, 6);

        selected_count = 20'd0;
        prev = ba0;
        seen = 0;
        for (int i = 0; i < 150; i++) begin
            capture_burst(st, a0, len, d0, hd, bad);
            if (prev == 95) begin
                chk("head_wrap_addr", a0, 0);
                seen = 1;
                break;
            end
            prev = a0;
        end
        chk("head_wrap_seen", seen, 1);

        for (int v = 0; v < 6; v++) begin
            for (int r = 0; r < vt[v].n_right; r++) begin
                pulse(0);
                if (m_space < 8) begin
                    m_space = m_space * 2;
                    expect_sweep(lc);
                end
            end
            for (int l = 0; l < vt[v].n_left; l++) begin
                pulse(1);
                if (m_space > 1) begin
                    m_space = m_space / 2;
                    expect_sweep(lc);
                end
            end
            for (int u = 0; u < vt[v].n_up; u++) begin
                pulse(2);
                m_thick = (m_thick == 8) ? 1 : m_thick * 2;
            end
            selected_count = 20'(vt[v].sel);
            volume_level   = 6'(vt[v].vol);
            chk($sformatf("v%0d_space", v), int'(bar_space), vt[v].exp_space);
            chk($sformatf("v%0d_thick", v), int'(bar_thickness), vt[v].exp_thick);
            capture_burst(st, a0, len, d0, hd, bad);
            capture_burst(bst, ba0, blen, bd0, bhd, bbad);
            capture_burst(st, a0, len, d0, hd, bad);
            chk($sformatf("v%0d_run", v), blen, vt[v].exp_run);
            chk($sformatf("v%0d_contig", v), bbad, 0);
            chk($sformatf("v%0d_data", v), bd0, vt[v].vol);
            chk($sformatf("v%0d_head", v), bhd, step(ba0, vt[v].exp_space));
            chk($sformatf("v%0d_next_addr", v), a0, step(ba0, vt[v].exp_space));
            chk($sformatf("v%0d_period", v), st - bst, vt[v].sel + 1 + vt[v].exp_run);
        end

        // Pause in the middle of a two-write burst.
        pulse(0);
        m_space = 2;
        expect_sweep(lc);
        selected_count = 20'd3;
        volume_level = 6'd21;
        k = 0;
        while (!(wr_bus.wr_en && !clear_busy) && k < 200) begin
            @(negedge clk);
            k++;
        end
        a = int'(wr_bus.wr_addr);
        h0 = int'(head_index);
        pause_switch = 1'b1;
        paused_wr = 0;
        @(negedge clk);
        if (wr_bus.wr_en) paused_wr++;
        pulse(0);
        if (wr_bus.wr_en) paused_wr++;
        @(negedge clk);
        if (wr_bus.wr_en || clear_busy) paused_wr++;
        chk("pause_wr_en", paused_wr, 0);
        chk("pause_head_hold", int'(head_index), h0);
        chk("pause_pulse_ignored", int'(bar_space), 2);
        pause_switch = 1'b0;
        @(negedge clk);
        chk("resume_wr_en", int'(wr_bus.wr_en), 1);
        chk("resume_addr", int'(wr_bus.wr_addr), a + 1);
        chk("resume_data", int'(wr_bus.wr_data), 21);
        @(negedge clk);
        chk("resume_head", int'(head_index), step(a, 2));

        // Spacing changes blocked by either menu switch.
        menu_switch = 1'b1;
        pulse(0);
        chk("menu_blocks_right", int'(bar_space), 2);
        watch_no_clear("menu_no_clear", 40);
        menu_switch = 1'b0;
        SW_2 = 1'b1;
        pulse(1);
        chk("sw2_blocks_left", int'(bar_space), 2);
        watch_no_clear("sw2_no_clear", 40);
        SW_2 = 1'b0;

        // Right and left together: right wins, single sweep.
        pulse(5);
        m_space = 4;
        chk("right_left_space", int'(bar_space), 4);
        expect_sweep(lc);
        watch_no_clear("right_left_single_sweep", 120);

        // pb_clear while the sweep is at address 50 restarts it from 0.
        pulse(3);
        k = 0;
        while (!(clear_busy && wr_bus.wr_addr == 7'd49) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("reach_addr49", int'(wr_bus.wr_addr), 49);
        pulse(3);
        chk("restart_gap_wr_en", int'(wr_bus.wr_en), 0);
        expect_sweep(lc);

        // Highlight window at head 10 and head 2, space 2, hilite_sel 2.
        pulse(1);
        m_space = 2;
        expect_sweep(lc);
        selected_count = 20'd200;
        wait_head(10, 3000);
        pulse(4);
        pulse(4);
        @(negedge clk);
        @(negedge clk);
`ifdef WAVE_HIST_HILITE_EN
        chk("hilite_valid_h10", int'(hilite_valid), 1);
        chk("hilite_lo_h10", int'(hilite_lo), 6);
        chk("hilite_hi_h10", int'(hilite_hi), 13);
`else
        chk("hilite_off_valid", int'(hilite_valid), 0);
        chk("hilite_off_bounds", int'({hilite_lo, hilite_hi}), 0);
`endif
        pulse(3);
        expect_sweep(lc);
        wait_head(2, 1000);
        @(negedge clk);
        @(negedge clk);
        chk("hilite_valid_h2", int'(hilite_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
